// File: rtl/alu_sched.sv
// alu_sched: shares one external combinational ALU between two requesters.
// Port A (fetch/branch) and port B (execute) compete through a round-robin
// grant. The granted operands are registered onto the ALU inputs and held
// for the operation latency (1 cycle, or MUL_LAT cycles for multiply), then
// the ALU result and zero flag are captured together with the requester id.
//
// Handshake: a request transfers on a rising edge where x_valid_i and
// x_ready_o are both high. Ready is combinational, high only in IDLE and
// offered to at most one port per cycle. A requester whose valid is high
// but not yet granted keeps its valid, operands and ctrl stable.
//
// Optional feature macro: ALU_SCHED_ERR_EN adds rsp_err_o (illegal-code
// flag captured with the response) and err_cnt_o (saturating count of
// illegal responses).
module alu_sched #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [WIDTH-1:0] a_data1_i,
    input  logic [WIDTH-1:0] a_data2_i,
    input  logic [2:0]       a_ctrl_i,
    input  logic             b_valid_i,
    output logic             b_ready_o,
    input  logic [WIDTH-1:0] b_data1_i,
    input  logic [WIDTH-1:0] b_data2_i,
    input  logic [2:0]       b_ctrl_i,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             alu_zero_i,
    output logic             rsp_valid_o,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_zero_o
`ifdef ALU_SCHED_ERR_EN
    ,
    output logic             rsp_err_o,
    output logic [7:0]       err_cnt_o
`endif
);

    localparam logic [2:0] CTRL_MUL = 3'b011;
    localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // state is left as a plain named signal so checkers can bind to it
    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       id_q;
    logic [3:0] cnt;
    logic       grant_id;
    logic       accept;
    logic       capture;
    logic       illegal;
    logic [2:0] sel_ctrl;

    // Round-robin grant selection and ready generation (IDLE only)
    always_comb begin
        grant_id = 1'b0;
        if (a_valid_i && b_valid_i) begin
            grant_id = ~last_grant;
        end else if (b_valid_i) begin
            grant_id = 1'b1;
        end
        a_ready_o = (state == IDLE) && !grant_id;
        b_ready_o = (state == IDLE) && grant_id;
        accept    = (a_ready_o && a_valid_i) || (b_ready_o && b_valid_i);
        sel_ctrl  = grant_id ? b_ctrl_i : a_ctrl_i;
        capture   = (state == BUSY) && (cnt == 4'd0);
        illegal   = (alu_ctrl_o == 3'b100) || (alu_ctrl_o == 3'b101);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, latency counter and response capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant  <= 1'b1;
            id_q        <= 1'b0;
            cnt         <= 4'd0;
            alu_data1_o <= '0;
            alu_data2_o <= '0;
            alu_ctrl_o  <= 3'b000;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_data_o  <= '0;
            rsp_zero_o  <= 1'b0;
        end else begin
            rsp_valid_o <= capture;
            if (accept) begin
                alu_data1_o <= grant_id ? b_data1_i : a_data1_i;
                alu_data2_o <= grant_id ? b_data2_i : a_data2_i;
                alu_ctrl_o  <= sel_ctrl;
                id_q        <= grant_id;
                last_grant  <= grant_id;
                cnt         <= (sel_ctrl == CTRL_MUL) ? MUL_CNT : 4'd0;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_id_o   <= id_q;
                rsp_data_o <= illegal ? '0 : alu_data_i;
                rsp_zero_o <= illegal ? 1'b1 : alu_zero_i;
            end
        end
    end

`ifdef ALU_SCHED_ERR_EN
    // Illegal-code flag and saturating illegal-response counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_err_o <= 1'b0;
            err_cnt_o <= 8'd0;
        end else if (capture) begin
            rsp_err_o <= illegal;
            if (illegal && err_cnt_o != 8'hFF) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: randomized and directed stimulus for alu_sched with a
// scoreboard. The stimulus process predicts grants and pushes expected
// responses; a separate monitor pops and compares on every rsp_valid_o.
module tb_alu_sched;
    localparam int W       = 32;
    localparam int MUL_LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_valid = 1'b0, b_valid = 1'b0;
    logic         a_ready, b_ready;
    logic [W-1:0] a_d1 = '0, a_d2 = '0, b_d1 = '0, b_d2 = '0;
    logic [2:0]   a_c = '0, b_c = '0;
    logic [W-1:0] alu_d1, alu_d2, alu_res;
    logic [2:0]   alu_c;
    logic         alu_zero;
    logic         rsp_valid, rsp_id, rsp_zero;
    logic [W-1:0] rsp_data;
`ifdef ALU_SCHED_ERR_EN
    logic         rsp_err;
    logic [7:0]   err_cnt;
`endif

    alu_sched #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready),
        .a_data1_i(a_d1), .a_data2_i(a_d2), .a_ctrl_i(a_c),
        .b_valid_i(b_valid), .b_ready_o(b_ready),
        .b_data1_i(b_d1), .b_data2_i(b_d2), .b_ctrl_i(b_c),
        .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .alu_ctrl_o(alu_c),
        .alu_data_i(alu_res), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id),
        .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero)
`ifdef ALU_SCHED_ERR_EN
        , .rsp_err_o(rsp_err), .err_cnt_o(err_cnt)
`endif
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU; illegal codes return garbage the scheduler must mask
    always_comb begin
        case (alu_c)
            3'b000:  alu_res = alu_d1 & alu_d2;
            3'b001:  alu_res = alu_d1 | alu_d2;
            3'b010:  alu_res = alu_d1 + alu_d2;
            3'b011:  alu_res = alu_d1 * alu_d2;
            3'b110:  alu_res = alu_d1 - alu_d2;
            3'b111:  alu_res = alu_d1 ^ alu_d2;
            default: alu_res = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_res == '0);
    end

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what a response should carry for a request
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [2:0] c);
        case (c)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b011:  return x * y;
            3'b110:  return x - y;
            3'b111:  return x ^ y;
            default: return '0;
        endcase
    endfunction

    // Scoreboard
    logic [W-1:0] exp_q[$];
    logic         exp_id_q[$];
    logic         exp_err_q[$];
    int           exp_cyc_q[$];
    logic [7:0]   exp_cnt_q[$];

    // Model state: pending requests per port, last grant, busy horizon
    logic         pend[2];
    logic [W-1:0] pd1[2], pd2[2];
    logic [2:0]   pc[2];
    logic         m_last;
    int           free_cyc;
    logic [W-1:0] cur_d1, cur_d2;
    logic [2:0]   cur_c;
    int           n_acc;
    int           m_err;

    // Monitor: every response pops one expected entry
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [W-1:0] ed;
                ed = exp_q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(ed));
                chk("rsp_zero", 64'(rsp_zero), 64'(ed == '0));
                chk("rsp_id", 64'(rsp_id), 64'(exp_id_q.pop_front()));
                chk("rsp_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
`ifdef ALU_SCHED_ERR_EN
                chk("rsp_err", 64'(rsp_err), 64'(exp_err_q.pop_front()));
                chk("err_cnt", 64'(err_cnt), 64'(exp_cnt_q.pop_front()));
`else
                void'(exp_err_q.pop_front());
                void'(exp_cnt_q.pop_front());
`endif
            end
        end
    end

    // Driver: queue a request on a port (held until granted)
    task automatic issue(input int p, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2:0] c);
        pend[p] = 1'b1; pd1[p] = x; pd2[p] = y; pc[p] = c;
    endtask

    // One cycle: drive pending requests, predict ready, record acceptance
    task automatic step();
        logic free, g;
        int lat;
        @(negedge clk);
        a_valid = pend[0]; a_d1 = pd1[0]; a_d2 = pd2[0]; a_c = pc[0];
        b_valid = pend[1]; b_d1 = pd1[1]; b_d2 = pd2[1]; b_c = pc[1];
        #1;
        free = (cyc >= free_cyc);
        g = (pend[0] && pend[1]) ? !m_last : pend[1];
        chk("ready", {62'd0, a_ready, b_ready}, {62'd0, free && !g, free && g});
        if (!free) begin
            chk("alu_hold", {29'd0, alu_c, alu_d1}, {29'd0, cur_c, cur_d1});
            chk("alu_hold2", 64'(alu_d2), 64'(cur_d2));
        end
        if (free && pend[g]) begin
            lat = (pc[g] == 3'b011) ? MUL_LAT : 1;
            exp_q.push_back(ref_res(pd1[g], pd2[g], pc[g]));
            exp_id_q.push_back(g);
            exp_cyc_q.push_back(cyc + 1 + lat);
            exp_err_q.push_back(pc[g] == 3'b100 || pc[g] == 3'b101);
            if (pc[g] == 3'b100 || pc[g] == 3'b101) m_err = (m_err < 255) ? m_err + 1 : 255;
            exp_cnt_q.push_back(8'(m_err));
            free_cyc = cyc + lat + 2;
            m_last = g;
            cur_d1 = pd1[g]; cur_d2 = pd2[g]; cur_c = pc[g];
            pend[g] = 1'b0;
            n_acc++;
        end
    endtask

    // Run until everything queued has been granted and answered
    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (!pend[0] && !pend[1] && cyc >= free_cyc && exp_q.size() == 0) done = 1'b1;
            else step();
        end
        chk("drain_timeout", 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        exp_q.delete(); exp_id_q.delete(); exp_cyc_q.delete();
        exp_err_q.delete(); exp_cnt_q.delete();
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1; free_cyc = 0; m_err = 0;
    endtask

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        n_acc = 0;
        do_reset();

        // Reset state
        #1;
        chk("rst_rsp", {60'd0, rsp_valid, rsp_id, rsp_zero, 1'b0}, 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);
        chk("rst_alu", {29'd0, alu_c, alu_d1}, 64'd0);
        chk("rst_ready", {62'd0, a_ready, b_ready}, 64'b10);
`ifdef ALU_SCHED_ERR_EN
        chk("rst_err", {55'd0, rsp_err, err_cnt}, 64'd0);
`endif

        // A only: add
        issue(0, 5, 7, 3'b010);
        drain();

        // Both valid from reset: A (and) first, then B (or)
        do_reset();
        issue(0, 32'hF0, 32'h0F, 3'b000);
        issue(1, 1, 2, 3'b001);
        drain();

        // Continuous dual requests: six grants must alternate
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 100 && n_acc < 6; i++) begin
            if (!pend[0]) issue(0, $urandom, $urandom, 3'($urandom_range(0, 2)));
            if (!pend[1]) issue(1, $urandom, $urandom, 3'($urandom_range(0, 2)));
            step();
        end
        chk("dual_count", 64'(n_acc), 64'd6);
        drain();

        // B multiply
        issue(1, 6, 7, 3'b011);
        drain();

        // A illegal code
        issue(0, 32'h1234, 32'h5678, 3'b101);
        drain();

        // Reset in BUSY during a multiply: no response, then A wins contention
        issue(1, 6, 7, 3'b011);
        step();
        step();
        do_reset();
        step();
        issue(0, 9, 9, 3'b110);
        issue(1, 3, 4, 3'b011);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (!pend[0] && $urandom_range(0, 3) != 0)
                issue(0, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 3'($urandom_range(0, 7)));
            if (!pend[1] && $urandom_range(0, 3) != 0)
                issue(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
            step();
        end
        drain();

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Shares one combinational ALU between two requesters (port A = fetch/branch side, port B = execute side).
- Uses a valid/ready handshake on each request port and a round-robin grant when both ports request.
- Holds the granted operands stable on the ALU inputs for the operation's latency, then returns the registered result and zero flag with the requester id.
- Treats multiply (ctrl 3'b011) as a multi-cycle operation.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_LAT, 3, number of cycles multiply operands are held before capture (legal range 1..15).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- a_valid_i  input  1  port A request valid.
- a_ready_o  output  1  port A request accepted this cycle when a_valid_i is also high.
- a_data1_i, a_data2_i  input  WIDTH  port A operands.
- a_ctrl_i  input  3  port A ALU control code.
- b_valid_i, b_ready_o, b_data1_i, b_data2_i, b_ctrl_i  same as port A, for port B.
- alu_data1_o, alu_data2_o  output  WIDTH  registered operands to the ALU.
- alu_ctrl_o  output  3  registered control code to the ALU.
- alu_data_i  input  WIDTH  ALU result.
- alu_zero_i  input  1  ALU zero flag.
- rsp_valid_o  output  1  one-cycle pulse marking a valid response.
- rsp_id_o  output  1  requester of the response: 0 = A, 1 = B.
- rsp_data_o  output  WIDTH  captured result.
- rsp_zero_o  output  1  captured zero flag.

Behaviour:
- Reset values:
  - state = IDLE; last_grant = 1, so A wins the first contention.
  - All outputs 0, except a_ready_o/b_ready_o, which follow IDLE.
  - Reset mid-operation drops the operation silently; no response is issued.
- States: IDLE, BUSY, RESP.
- Ready generation: a_ready_o and b_ready_o are combinational and high only in IDLE.
  - Only one of them is high in any cycle. If both valids are high, ready goes to the port not equal to last_grant.
  - If one valid is high, that port gets ready.
  - If no valid is high, ready defaults to A.
- IDLE: on a handshake at edge N:
  - latch operands/ctrl into alu_*_o, latch id, set last_grant = id;
  - load cnt = MUL_LAT-1 if ctrl == 3'b011, else 0;
  - go to BUSY.
- BUSY:
  - Hold alu_*_o constant.
  - When cnt == 0, capture alu_data_i into rsp_data_o and alu_zero_i into rsp_zero_o, assert rsp_valid_o, and go to RESP.
  - Otherwise decrement cnt.
  - Non-multiply ops capture at edge N+1; multiply captures at edge N+MUL_LAT.
- RESP:
  - rsp_valid_o is high for exactly this one cycle; rsp_id_o/rsp_data_o/rsp_zero_o stay held until the next capture.
  - The next edge returns to IDLE, so the next acceptance is no earlier than edge N+L+2 (L = 1 or MUL_LAT).
- Illegal ctrl codes (3'b100, 3'b101):
  - Accepted and run with latency 1.
  - Response forced to rsp_data_o = 0, rsp_zero_o = 1, independent of alu_data_i.
- A request with valid high but not granted must be held stable by the requester. The block never drops or reorders a granted request.
- Zero flag: the registered copy of alu_zero_i is forwarded, except for illegal codes as above.

Optional Feature:
- Macro: ALU_SCHED_ERR_EN.
- Defined:
  - Adds output rsp_err_o (1 bit, reset 0), captured with the response: 1 for illegal ctrl codes, 0 otherwise.
  - Adds an 8-bit saturating counter err_cnt_o of illegal responses; it saturates at 255 and is cleared by rst_i.
- Undefined: neither port exists; illegal codes still return data 0 / zero 1.

Test Plan:
- Reset then A only: A add (5, 7, ctrl 010) -> rsp_valid_o pulse 2 cycles after acceptance edge, rsp_id_o=0, rsp_data_o=12, rsp_zero_o=0.
- Both valid from reset: A and (0xF0, 0x0F, 000) with B or (1, 2, 001) -> A served first (data 0, zero 1), then B (data 3, id 1); b_ready_o stays low until the cycle after A's RESP.
- Continuous dual requests for 6 ops -> grants alternate A, B, A, B, A, B; no requester is granted twice in a row.
- B multiply (6, 7, 011), MUL_LAT=3 -> alu_*_o stable for 3 cycles, capture at N+3, rsp_data_o=42, id 1; a_ready_o stays 0 throughout.
- A ctrl 3'b101 -> rsp_data_o=0, rsp_zero_o=1; with ALU_SCHED_ERR_EN, rsp_err_o=1 and err_cnt_o increments 0->1.
- rst_i asserted in BUSY during a multiply -> no rsp_valid_o pulse, state IDLE next cycle; A wins a subsequent simultaneous request.
